// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
// Shared types and constants for the SPI initiator.
//   state_t  : transfer FSM states
//   LEN_W    : width of the bit-count field of a request
//   DIV_W    : width of the sck half-period divider
//   IDLE_*   : pin levels driven while no frame is active
//   eff_len  : maps a requested bit count onto the bit count actually used
// -----------------------------------------------------------------------------
package spi_master_pkg;

    localparam int LEN_W = 5;
    localparam int DIV_W = 8;

    localparam logic IDLE_SCK  = 1'b0;
    localparam logic IDLE_MOSI = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        RESP
    } state_t;

    // A count of zero, or one larger than the data path, means "full width".
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned      data_w);
        if (len == '0 || 32'(len) > data_w)
            return LEN_W'(data_w);
        return len;
    endfunction

endpackage

// File: rtl/spi_phase_cnt.sv
// -----------------------------------------------------------------------------
// spi_phase_cnt
// Loadable down-counter that marks the end of each sck phase. After a load
// with divider value D, and while enabled, o_phase_done pulses for one clock
// every D+1 clocks; the counter reloads itself from the latched divider.
//   clock/reset_n : system clock, async active-low reset
//   i_load        : latch i_div and restart the count
//   i_div         : phase length in clocks, minus 1
//   i_en          : count while high
//   o_phase_done  : last clock of the current phase
// -----------------------------------------------------------------------------
module spi_phase_cnt
    import spi_master_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_en,
    output logic             o_phase_done
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= i_div;
        end else if (i_en) begin
            if (r_cnt == '0)
                r_cnt <= r_div;
            else
                r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_phase_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// SPI mode-0, MSB-first initiator. Each accepted request runs one
// chip-select-framed transfer of 1..DATA_W bits and returns the received bits.
//   clock/reset_n          : system clock, async active-low reset
//   req_valid/req_ready    : request handshake
//   req_data/len/ss/div    : tx bits (right-aligned), bit count, one-hot
//                            select, sck half-period minus 1
//   rsp_valid/rsp_ready    : response handshake
//   rsp_data               : rx bits, right-aligned, upper bits zero
//   busy                   : any state other than IDLE
//   sck/ss_n/mosi/miso     : SPI pins (all outputs registered)
// -----------------------------------------------------------------------------
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SS_W   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [SS_W-1:0]   req_ss,
    input  logic [DIV_W-1:0]  req_div,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              sck,
    output logic [SS_W-1:0]   ss_n,
    output logic              mosi,
    input  logic              miso
);

    state_t            r_state;
    logic              r_sck;
    logic [SS_W-1:0]   r_ss_n;
    logic              r_mosi;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_busy;
    logic              r_req_ready;
    logic [DATA_W-1:0] r_tx;     // remaining tx bits, next one at the MSB
    logic [DATA_W-1:0] r_rx;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_bits;   // bits sampled so far

    logic              w_accept;
    logic              w_cnt_en;
    logic              w_phase_done;
    logic [LEN_W-1:0]  w_len_eff;
    logic [DATA_W-1:0] w_tx_align;

    assign w_accept   = (r_state == IDLE) && req_valid;
    assign w_cnt_en   = (r_state == SETUP) || (r_state == HIGH) || (r_state == LOW);
    assign w_len_eff  = eff_len(req_len, DATA_W);
    // Left-align the request so the first bit to send sits at the MSB.
    assign w_tx_align = req_data << (LEN_W'(DATA_W) - w_len_eff);

    spi_phase_cnt u_phase_cnt (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_load       (w_accept),
        .i_div        (req_div),
        .i_en         (w_cnt_en),
        .o_phase_done (w_phase_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sck       <= IDLE_SCK;
            r_ss_n      <= '1;
            r_mosi      <= IDLE_MOSI;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_tx        <= '0;
            r_rx        <= '0;
            r_len       <= '0;
            r_bits      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state     <= SETUP;
                        r_ss_n      <= ~req_ss;
                        r_mosi      <= w_tx_align[DATA_W-1];
                        r_tx        <= w_tx_align << 1;
                        r_rx        <= '0;
                        r_len       <= w_len_eff;
                        r_bits      <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (w_phase_done) begin
                        r_state <= HIGH;
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[DATA_W-2:0], miso};
                        r_bits  <= r_bits + LEN_W'(1);
                    end
                end
                HIGH: begin
                    if (w_phase_done) begin
                        r_state <= LOW;
                        r_sck   <= 1'b0;
                        // After the last sample mosi holds its value through
                        // the final low phase.
                        if (r_bits != r_len) begin
                            r_mosi <= r_tx[DATA_W-1];
                            r_tx   <= r_tx << 1;
                        end
                    end
                end
                LOW: begin
                    if (w_phase_done) begin
                        if (r_bits == r_len) begin
                            r_state     <= RESP;
                            r_ss_n      <= '1;
                            r_mosi      <= IDLE_MOSI;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_rx;
                        end else begin
                            r_state <= HIGH;
                            r_sck   <= 1'b1;
                            r_rx    <= {r_rx[DATA_W-2:0], miso};
                            r_bits  <= r_bits + LEN_W'(1);
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign sck       = r_sck;
    assign ss_n      = r_ss_n;
    assign mosi      = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master. A cycle-level reference predicts every pin
// from the request (frame length, phase index, bit index) and is compared on
// each falling clock edge; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_master;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [15:0] req_data;
    logic [4:0]  req_len;
    logic [7:0]  req_ss, req_div;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        busy, sck, mosi, miso;
    logic [7:0]  ss_n;
    int          miso_mode;   // 0: tied 0, 1: tied 1, 2: loopback

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    assign miso = (miso_mode == 2) ? mosi : miso_mode[0];

    spi_master dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .req_ss    (req_ss),
        .req_div   (req_div),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sck       (sck),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_st = 0;      // 0 idle, 1 frame, 2 response
    int          m_t, m_len, m_div, m_n;
    logic [15:0] m_data, m_rx;
    logic [15:0] m_rsp = 16'h0;
    logic [7:0]  m_ss;

    always @(negedge clock) begin
        int p, bi, mask;
        logic e_sck, e_mosi, e_rv, e_rdy, e_busy;
        logic [7:0] e_ss;
        if (!reset_n) begin
            chk("rst_sck", 32'(sck), 0);
            chk("rst_ss_n", 32'(ss_n), 32'hFF);
            chk("rst_mosi", 32'(mosi), 1);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            chk("rst_busy", 32'(busy), 0);
            m_st  = 0;
            m_rsp = 16'h0;
        end else begin
            e_sck = 0; e_mosi = 1; e_rv = 0; e_rdy = 0; e_busy = 1; e_ss = 8'hFF;
            case (m_st)
                0: begin e_rdy = 1; e_busy = 0; end
                1: begin
                    p  = (m_t - 1) / (m_div + 1);
                    e_sck = (p % 2 == 1);
                    bi = p / 2;
                    if (bi > m_len - 1) bi = m_len - 1;
                    e_mosi = m_data[m_len - 1 - bi];
                    e_ss = ~m_ss;
                end
                default: e_rv = 1;
            endcase
            chk("sck", 32'(sck), 32'(e_sck));
            chk("mosi", 32'(mosi), 32'(e_mosi));
            chk("ss_n", 32'(ss_n), 32'(e_ss));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
            // advance to the next cycle using the inputs the next edge will see
            case (m_st)
                0: if (req_valid) begin
                    m_st   = 1;
                    m_t    = 1;
                    m_len  = (req_len == 0 || req_len > 16) ? 16 : int'(req_len);
                    m_div  = int'(req_div);
                    m_data = req_data;
                    m_ss   = req_ss;
                    m_n    = (2 * m_len + 1) * (m_div + 1);
                    mask   = (1 << m_len) - 1;
                    m_rx   = (miso_mode == 2) ? 16'(req_data & mask) :
                             (miso_mode == 1) ? 16'(mask) : 16'h0;
                end
                1: if (m_t == m_n) begin m_st = 2; m_rsp = m_rx; end
                   else m_t++;
                default: if (rsp_ready) m_st = 0;
            endcase
        end
    end

    // ---------------- driver helpers ----------------
    // Called just after a rising edge; returns just after the accept edge.
    task automatic send_req(input logic [15:0] d, input logic [4:0] l,
                            input logic [7:0] s, input logic [7:0] dv);
        logic rdy;
        int   n;
        req_data = d; req_len = l; req_ss = s; req_div = dv; req_valid = 1;
        n = 0;
        do begin
            @(negedge clock); rdy = req_ready;
            @(posedge clock); #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("accept_timeout", 1, 0);
        req_valid = 0;
    endtask

    // Returns at the falling edge where rsp_valid is first seen.
    task automatic wait_rsp(output int lat, output int sslow, output int pulses,
                            output logic [7:0] first_ss);
        logic prev = 0;
        lat = 0; sslow = 0; pulses = 0; first_ss = 8'hFF;
        do begin
            @(negedge clock);
            lat++;
            if (ss_n != 8'hFF) begin
                if (sslow == 0) first_ss = ss_n;
                sslow++;
            end
            if (sck && !prev) pulses++;
            prev = sck;
        end while (!rsp_valid && lat < 5000);
        if (!rsp_valid) chk("rsp_timeout", 1, 0);
    endtask

    task automatic take_rsp();
        @(posedge clock); #1 rsp_ready = 1;
        @(posedge clock); #1 rsp_ready = 0;
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        int lat, sl, pl, cnt;
        logic [7:0] fss;
        logic prev;
        reset_n = 0; req_valid = 0; rsp_ready = 0; req_data = 0; req_len = 0;
        req_ss = 0; req_div = 0; miso_mode = 2;
        repeat (3) @(posedge clock);
        #1 reset_n = 1;

        // 1: loopback, full width, fastest sck
        send_req(16'hA5C3, 5'd16, 8'h01, 8'd0);
        wait_rsp(lat, sl, pl, fss);
        chk("t1_rsp", 32'(rsp_data), 32'hA5C3);
        chk("t1_sslow", sl, 33);
        chk("t1_pulses", pl, 16);
        chk("t1_latency", lat, 34);
        chk("t1_ss", 32'(fss), 32'hFE);
        take_rsp();

        // 2: loopback, 8 bits, 4-clock phases
        send_req(16'hFF81, 5'd8, 8'h01, 8'd3);
        wait_rsp(lat, sl, pl, fss);
        chk("t2_rsp", 32'(rsp_data), 32'h0081);
        chk("t2_sslow", sl, 68);
        chk("t2_pulses", pl, 8);
        take_rsp();

        // 3: miso tied low, len 0 means full width
        miso_mode = 0;
        send_req(16'hFFFF, 5'd0, 8'h01, 8'd0);
        wait_rsp(lat, sl, pl, fss);
        chk("t3_rsp", 32'(rsp_data), 32'h0000);
        chk("t3_pulses", pl, 16);
        take_rsp();
        miso_mode = 2;

        // 4: response held off for 10 cycles with a request pending
        send_req(16'h3C5A, 5'd12, 8'h02, 8'd0);
        wait_rsp(lat, sl, pl, fss);
        @(posedge clock); #1;
        req_data = 16'h0F0F; req_len = 5'd8; req_ss = 8'h10; req_div = 8'd0;
        req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t4_hold_valid", 32'(rsp_valid), 1);
            chk("t4_hold_data", 32'(rsp_data), 32'h0C5A);
            chk("t4_hold_ready", 32'(req_ready), 0);
            @(posedge clock); #1;
        end
        rsp_ready = 1;
        @(posedge clock); #1 rsp_ready = 0;
        @(negedge clock);
        chk("t4_ready_after_hs", 32'(req_ready), 1);
        chk("t4_not_yet_framed", 32'(ss_n), 32'hFF);
        @(posedge clock); #1 req_valid = 0;
        @(negedge clock);
        chk("t4_next_ss", 32'(ss_n), 32'hEF);
        wait_rsp(lat, sl, pl, fss);
        chk("t4_next_rsp", 32'(rsp_data), 32'h000F);
        take_rsp();

        // 5: reset in the middle of a frame
        send_req(16'h1234, 5'd16, 8'h04, 8'd1);
        cnt = 0; prev = 0;
        for (int i = 0; i < 200 && cnt < 5; i++) begin
            @(negedge clock);
            if (sck && !prev) cnt++;
            prev = sck;
        end
        chk("t5_pulses_seen", cnt, 5);
        #2 reset_n = 0;
        #1;
        chk("t5_sck", 32'(sck), 0);
        chk("t5_ss_n", 32'(ss_n), 32'hFF);
        chk("t5_mosi", 32'(mosi), 1);
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        send_req(16'h00B7, 5'd8, 8'h04, 8'd1);
        wait_rsp(lat, sl, pl, fss);
        chk("t5_after_rsp", 32'(rsp_data), 32'h00B7);
        chk("t5_after_sslow", sl, 34);
        take_rsp();

        // 6: back-to-back frames on different selects
        send_req(16'h1111, 5'd4, 8'h01, 8'd0);
        wait_rsp(lat, sl, pl, fss);
        chk("t6a_ss", 32'(fss), 32'hFE);
        chk("t6a_rsp", 32'(rsp_data), 32'h0001);
        take_rsp();
        req_data = 16'h00F0; req_len = 5'd8; req_ss = 8'h80; req_div = 8'd1;
        req_valid = 1;
        @(negedge clock);
        chk("t6_gap", 32'(ss_n), 32'hFF);
        @(posedge clock); #1 req_valid = 0;
        wait_rsp(lat, sl, pl, fss);
        chk("t6b_ss", 32'(fss), 32'h7F);
        chk("t6b_rsp", 32'(rsp_data), 32'h00F0);
        take_rsp();

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI initiator (mode 0, MSB-first) that drives `sck`/`ss_n`/`mosi` toward SPI peripherals such as the bit-reversal test device and captures `miso`. Sits between a core-side valid/ready command port and the off-chip SPI pins. Each accepted request performs one chip-select-framed transfer of 1..DATA_W bits and returns the received bits on a valid/ready response port.

## Interface
- DATA_W, 16, max bits per transfer and width of request/response data
- SS_W, 8, number of slave-select lines
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_data  in  DATA_W  transmit bits, right-aligned; bit [len-1] sent first
- req_len  in  5  bit count; 0 or >DATA_W treated as DATA_W
- req_ss  in  SS_W  one-hot slave select
- req_div  in  8  half-period of sck in clocks, minus 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  DATA_W  received bits right-aligned, first-received in bit [len-1], upper bits 0
- busy  out  1  high in every state except IDLE
- sck  out  1  SPI clock, idles low
- ss_n  out  SS_W  active-low selects, idle all ones
- mosi  out  1  master out
- miso  in  1  master in; sampled as-is (synchronisation is the caller's job)

## Operation
- States: IDLE, SETUP, HIGH, LOW, RESP.
- IDLE: req_ready=1. On req_valid: latch data, effective len, ss, div; go SETUP. req_ready=0 in all other states.
- SETUP: ss_n=~ss, sck=0, mosi=data[len-1]; lasts div+1 clocks, then HIGH.
- HIGH: sck=1 for div+1 clocks; on the edge entering HIGH, shift miso into rx LSB. At end: if bits_done==len go LOW as final hold phase, else go LOW and present next mosi bit on the edge entering LOW.
- LOW: sck=0 for div+1 clocks; then HIGH if bits remain, else RESP.
- RESP: ss_n=all ones, sck=0, mosi=1, rsp_valid=1, rsp_data stable; on rsp_ready go IDLE. No new request is accepted until the response is consumed.
- Bit counter counts sampled bits 0..len; phase counter counts 0..div and reloads each phase; div=0 gives sck=clock/2.
- mosi is 1 whenever ss_n is all ones.
- Reset (any time, including mid-transfer): state IDLE, sck=0, ss_n=all ones, mosi=1, rsp_valid=0, rsp_data=0, busy=0, req_ready=1 after release. No response is generated for an aborted transfer.
- req_ss with zero or multiple bits is driven through as given; no checking.

## Timing
- All outputs registered; no combinational path input->output.
- Accept at edge T0: ss_n asserted and first mosi valid from T0+1.
- ss_n low for exactly (2*len+1)*(div+1) clocks; rsp_valid rises the same cycle ss_n deasserts.
- Request-to-response latency: (2*len+1)*(div+1)+1 clocks from the accept edge.
- miso sampled on the clock edge where sck goes 0->1; mosi changes only on 1->0 edges (and at SETUP entry).
- Back-to-back: next req_ready one cycle after rsp handshake; ss_n high for at least one clock between transfers.

## Structure
- Package spi_master_pkg: state enum (IDLE, SETUP, HIGH, LOW, RESP), LEN_W=5, DIV_W=8, idle pin constants.
- One sub-module spi_phase_cnt: loadable down-counter producing a one-cycle phase_done pulse every div+1 clocks while enabled.
- Top holds FSM, tx/rx shift registers, bit counter, and pin registers.

## Test plan
- Loopback (miso=mosi), len=16, div=0, data=0xA5C3, ss=0x01 -> ss_n=0xFE for 33 clocks, 16 sck pulses, rsp_data=0xA5C3, latency 34 clocks.
- Loopback, len=8, div=3, data=0xFF81 -> rsp_data=0x0081, sck high/low phases 4 clocks each, ss_n low 68 clocks.
- miso tied 0, len=0 (treated 16), data=0xFFFF -> 16 sck pulses, mosi all 1s inside frame, rsp_data=0x0000.
- rsp_ready held low 10 cycles after rsp_valid -> rsp_valid/rsp_data stable, req_ready=0, a pending req_valid is not accepted until the cycle after the handshake.
- reset_n asserted after 5 sck pulses -> same-cycle sck=0, ss_n=0xFF, mosi=1, rsp_valid=0; next request after release completes normally.
- Two back-to-back requests with ss=0x01 then 0x80 -> ss_n high for at least 1 clock between frames, correct select each frame.
